uart_rx_core: RTL and testbench

//  Serial receiver: the stage directly downstream of the 16x RX baud generator.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_core.sv | 155 +++++++++++++++
 tb/tb_uart_rx_core.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Used by both the RX and TX halves of the UART.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_PARITY    = 3'd3,
      RX_STOP      = 3'd4,
      RX_WAIT_IDLE = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so the receiver sees an idle line coming out of reset.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with a one-entry holding register and valid/ack handshake.
// Define UART_RX_PARITY_EN to receive even-parity frames and drive parity_err.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_16x,
   input  logic                 rx_in,
   input  logic                 data_ack,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q, state_n;
   logic [TW-1:0]        tick_q, tick_n;
   logic [BW-1:0]        bit_q, bit_n;
   logic [DATA_BITS-1:0] shift_q, shift_n;
   logic                 load, ferr_n;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rx_s)
   );

`ifdef UART_RX_PARITY_EN
   logic perr_n, perr_q;
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      tick_n  = tick_q;
      bit_n   = bit_q;
      shift_n = shift_q;
      load    = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_n  = 1'b0;
`endif
      if (tick_16x) begin
         case (state_q)
            RX_IDLE: begin
               if (!rx_s) begin
                  state_n = RX_START;
                  tick_n  = '0;
               end
            end
            RX_START: begin
               // A start bit that is high again by mid-bit is a glitch.
               if (tick_q == TICK_MID) begin
                  tick_n = '0;
                  bit_n  = '0;
                  state_n = rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (tick_q == TICK_END) begin
                  shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_n   = bit_q + 1'b1;
                  tick_n  = '0;
                  if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_n = RX_PARITY;
`else
                     state_n = RX_STOP;
`endif
                  end
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
               if (tick_q == TICK_END) begin
                  perr_n  = rx_s ^ (^shift_q);
                  tick_n  = '0;
                  state_n = RX_STOP;
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (tick_q == TICK_END) begin
                  tick_n = '0;
                  if (rx_s) begin
                     load    = 1'b1;
                     state_n = RX_IDLE;
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = RX_WAIT_IDLE;
                  end
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
            RX_WAIT_IDLE: begin
               if (rx_s) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RX_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q   <= state_n;
         tick_q    <= tick_n;
         bit_q     <= bit_n;
         shift_q   <= shift_n;
         frame_err <= ferr_n;
         if (load) data_out <= shift_q;
         // A load beats a same-cycle ack; overrun only when unacked data is replaced.
         data_valid <= load | (data_valid & ~data_ack);
         overrun    <= load & data_valid & ~data_ack;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) perr_q <= 1'b0;
      else     perr_q <= perr_n;
   end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed plus randomized frames against a frame-level model of the receiver.
// Honours UART_RX_PARITY_EN so the same bench covers both builds.
module tb_uart_rx_core;

   localparam int TICK_DIV = 27;
   localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1, tick_16x = 1'b0, rx_in = 1'b1, data_ack = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, frame_err, overrun, parity_err;

   int tests = 0, fails = 0;
   int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;

   // frame-level reference model
   logic       exp_valid = 1'b0;
   logic [7:0] exp_data = 8'h00;
   int         exp_ferr = 0, exp_ovr = 0, exp_perr = 0;

   uart_rx_core dut (
      .clk        (clk),
      .rst        (rst),
      .tick_16x   (tick_16x),
      .rx_in      (rx_in),
      .data_ack   (data_ack),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #10 clk = ~clk;

   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(posedge clk);
         #1 tick_16x = 1'b1;
         @(posedge clk);
         #1 tick_16x = 1'b0;
      end
   end

   // every high cycle counts, so a stretched pulse shows up as an extra event
   always @(negedge clk) begin
      if (frame_err)  ferr_cnt++;
      if (overrun)    ovr_cnt++;
      if (parity_err) perr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, 32'(data_valid), 32'(exp_valid));
      check({tag, ".data"},  32'(data_out),   32'(exp_data));
      check({tag, ".ferr"},  32'(ferr_cnt),   32'(exp_ferr));
      check({tag, ".ovr"},   32'(ovr_cnt),    32'(exp_ovr));
      check({tag, ".perr"},  32'(perr_cnt),   32'(exp_perr));
   endtask

   task automatic hold_bit(input logic b);
      rx_in = b;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(d[i]);
      if (PAR_EN) hold_bit((^d) ^ par_flip);
      hold_bit(stop_b);
      rx_in = 1'b1;
      repeat (BIT_CLKS / 2) @(posedge clk);
      #1;
      if (PAR_EN && par_flip) exp_perr++;
      if (stop_b) begin
         if (exp_valid) exp_ovr++;
         exp_data  = d;
         exp_valid = 1'b1;
      end else begin
         exp_ferr++;
      end
   endtask

   task automatic do_ack();
      data_ack = 1'b1;
      @(posedge clk);
      #1 data_ack = 1'b0;
      @(posedge clk);
      #1 exp_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      logic       rs;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;
      repeat (BIT_CLKS) @(posedge clk);
      #1;

      send_frame(8'hA5, 1'b1, 1'b0);
      check_all("a5");
      do_ack();
      check("a5_ack", 32'(data_valid), 32'(exp_valid));

      // ack with nothing held is ignored
      do_ack();
      check_all("ack_idle");

      // short low pulse must not start a frame
      rx_in = 1'b0;
      repeat (4 * TICK_DIV) @(posedge clk);
      #1 rx_in = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge clk);
      #1;
      check_all("glitch");

      send_frame(8'h3C, 1'b0, 1'b0);
      check_all("ferr_3c");
      send_frame(8'h11, 1'b1, 1'b0);
      check_all("after_ferr_11");
      do_ack();

      send_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'h02, 1'b1, 1'b0);
      check_all("overrun_02");

      // reset in the middle of the data bits clears everything at once
      hold_bit(1'b0);
      for (int i = 0; i < 3; i++) hold_bit(1'b1);
      #5 rst = 1'b1;
      #1;
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      check_all("mid_rst");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rx_in = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
      send_frame(8'h7E, 1'b1, 1'b0);
      check_all("after_rst_7e");
      do_ack();

      for (int k = 0; k < 3; k++) begin
         rd = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 3) != 0);
         send_frame(rd, rs, 1'b0);
         check_all($sformatf("rand%0d", k));
         if ($urandom_range(0, 1) == 1) begin
            do_ack();
            check($sformatf("rand%0d_ack", k), 32'(data_valid), 32'(exp_valid));
         end
      end

      if (PAR_EN) begin
         do_ack();
         send_frame(8'h0F, 1'b1, 1'b1);
         check_all("par_bad_0f");
         do_ack();
         send_frame(8'h0F, 1'b1, 1'b0);
         check_all("par_good_0f");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
